// File: rtl/mastermind_score.sv
// mastermind_score: sequential Mastermind scorer.
// Captures a guess/secret pair on start, counts exact matches one position per
// cycle, then counts colour-only matches one (guess, secret) pair per cycle
// using match masks so every peg is counted at most once.
// Optional feature macro: SCORE_WIN_EN adds the registered 'win' output.
module mastermind_score #(
    parameter int NUM_PEGS = 5,
    parameter int COLOR_W  = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [NUM_PEGS*COLOR_W-1:0] guess,
    input  logic [NUM_PEGS*COLOR_W-1:0] secret,
    output logic                        busy,
    output logic                        done,
    output logic [2:0]                  c_place,
`ifdef SCORE_WIN_EN
    output logic [2:0]                  c_color,
    output logic                        win
`else
    output logic [2:0]                  c_color
`endif
);

    localparam int         PW   = NUM_PEGS * COLOR_W;
    localparam logic [2:0] LAST = 3'(NUM_PEGS - 1);
    localparam logic [2:0] FULL = 3'(NUM_PEGS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXACT = 2'd1,
        COLOR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         guess_q, guess_d;
    logic [PW-1:0]         secret_q, secret_d;
    logic [NUM_PEGS-1:0]   gmask_q, gmask_d;
    logic [NUM_PEGS-1:0]   smask_q, smask_d;
    logic [2:0]            g_q, g_d;
    logic [2:0]            s_q, s_d;
    logic [2:0]            place_q, place_d;
    logic [2:0]            color_q, color_d;
    logic [2:0]            c_place_q, c_place_d;
    logic [2:0]            c_color_q, c_color_d;
    logic                  done_q, done_d;
`ifdef SCORE_WIN_EN
    logic                  win_q, win_d;
`endif

    // Extract peg 'idx' from a packed code vector.
    function automatic logic [COLOR_W-1:0] peg(input logic [PW-1:0] v, input logic [2:0] idx);
        return v[int'(idx) * COLOR_W +: COLOR_W];
    endfunction

    // Next-state, datapath and result-register update logic.
    always_comb begin
        state_d   = state_q;
        guess_d   = guess_q;
        secret_d  = secret_q;
        gmask_d   = gmask_q;
        smask_d   = smask_q;
        g_d       = g_q;
        s_d       = s_q;
        place_d   = place_q;
        color_d   = color_q;
        c_place_d = c_place_q;
        c_color_d = c_color_q;
        done_d    = 1'b0;
`ifdef SCORE_WIN_EN
        win_d     = win_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    guess_d  = guess;
                    secret_d = secret;
                    gmask_d  = '0;
                    smask_d  = '0;
                    g_d      = 3'd0;
                    s_d      = 3'd0;
                    place_d  = 3'd0;
                    color_d  = 3'd0;
                    state_d  = EXACT;
                end else begin
                    state_d  = IDLE;
                end
            end
            EXACT: begin
                if (peg(guess_q, g_q) == peg(secret_q, g_q)) begin
                    place_d      = place_q + 3'd1;
                    gmask_d[g_q] = 1'b1;
                    smask_d[g_q] = 1'b1;
                end else begin
                    place_d      = place_q;
                end
                if (g_q == LAST) begin
                    g_d     = 3'd0;
                    state_d = COLOR;
                end else begin
                    g_d     = g_q + 3'd1;
                end
            end
            COLOR: begin
                // Only unmatched pegs on both sides may pair up.
                if (!gmask_q[g_q] && !smask_q[s_q] && (peg(guess_q, g_q) == peg(secret_q, s_q))) begin
                    color_d      = color_q + 3'd1;
                    gmask_d[g_q] = 1'b1;
                    smask_d[s_q] = 1'b1;
                end else begin
                    color_d      = color_q;
                end
                if (s_q == LAST) begin
                    s_d = 3'd0;
                    if (g_q == LAST) begin
                        g_d     = 3'd0;
                        state_d = DONE;
                    end else begin
                        g_d     = g_q + 3'd1;
                    end
                end else begin
                    s_d = s_q + 3'd1;
                end
            end
            DONE: begin
                c_place_d = place_q;
                c_color_d = color_q;
                done_d    = 1'b1;
`ifdef SCORE_WIN_EN
                win_d     = (place_q == FULL);
`endif
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            guess_q   <= '0;
            secret_q  <= '0;
            gmask_q   <= '0;
            smask_q   <= '0;
            g_q       <= 3'd0;
            s_q       <= 3'd0;
            place_q   <= 3'd0;
            color_q   <= 3'd0;
            c_place_q <= 3'd0;
            c_color_q <= 3'd0;
            done_q    <= 1'b0;
`ifdef SCORE_WIN_EN
            win_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            guess_q   <= guess_d;
            secret_q  <= secret_d;
            gmask_q   <= gmask_d;
            smask_q   <= smask_d;
            g_q       <= g_d;
            s_q       <= s_d;
            place_q   <= place_d;
            color_q   <= color_d;
            c_place_q <= c_place_d;
            c_color_q <= c_color_d;
            done_q    <= done_d;
`ifdef SCORE_WIN_EN
            win_q     <= win_d;
`endif
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign c_place = c_place_q;
    assign c_color = c_color_q;
`ifdef SCORE_WIN_EN
    assign win     = win_q;
`endif

endmodule

// File: tb/tb_mastermind_score.sv
// Directed self-checking bench for mastermind_score (NUM_PEGS=5, COLOR_W=3).
module tb_mastermind_score;

    logic        clk;
    logic        reset;
    logic        start;
    logic [14:0] guess;
    logic [14:0] secret;
    logic        busy;
    logic        done;
    logic [2:0]  c_place;
    logic [2:0]  c_color;
`ifdef SCORE_WIN_EN
    logic        win;
`endif

    int checks   = 0;
    int failures = 0;

    mastermind_score #(.NUM_PEGS(5), .COLOR_W(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .guess   (guess),
        .secret  (secret),
        .busy    (busy),
        .done    (done),
        .c_place (c_place),
`ifdef SCORE_WIN_EN
        .c_color (c_color),
        .win     (win)
`else
        .c_color (c_color)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Peg 0 is the first argument (least significant field).
    function automatic logic [14:0] pk(input int a, input int b, input int c, input int d, input int e);
        return {3'(e), 3'(d), 3'(c), 3'(b), 3'(a)};
    endfunction

    // Starts a scoring run and returns right after the edge that raises done.
    task automatic score(input logic [14:0] g, input logic [14:0] s, input int ep, input int ec,
                         input int restart_at, input bit dc_start, input string tag);
        int  edges;
        bit  held;
        bit  busy_ok;
        logic [2:0] prev_p;
        logic [2:0] prev_c;
        prev_p = c_place;
        prev_c = c_color;
        @(negedge clk);
        guess  = g;
        secret = s;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        guess   = ~g;
        secret  = ~s;
        edges   = 0;
        held    = 1'b1;
        busy_ok = 1'b1;
        while (!done && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
            if (!done) begin
                if (c_place != prev_p || c_color != prev_c) held = 1'b0;
                if (!busy) busy_ok = 1'b0;
            end
            if (edges == restart_at) begin
                start = 1'b1;
                guess = 15'd0;
            end else if (edges == restart_at + 1) begin
                start = 1'b0;
            end
            if (dc_start && edges == 30) begin
                start = 1'b1;
                guess = 15'd0;
            end
        end
        start = 1'b0;
        check({tag, "_latency"}, edges, 31);
        check({tag, "_place"}, int'(c_place), ep);
        check({tag, "_color"}, int'(c_color), ec);
        check({tag, "_hold"}, int'(held), 1);
        check({tag, "_busy"}, int'(busy_ok), 1);
        check({tag, "_idle_at_done"}, int'(busy), 0);
`ifdef SCORE_WIN_EN
        check({tag, "_win"}, int'(win), (ep == 5) ? 1 : 0);
`endif
    endtask

    // One cycle after done: pulse over, still idle, results held.
    task automatic check_idle(input string tag, input int ep, input int ec);
        @(posedge clk);
        #1;
        check({tag, "_done_pulse"}, int'(done), 0);
        check({tag, "_busy_after"}, int'(busy), 0);
        check({tag, "_place_held"}, int'(c_place), ep);
        check({tag, "_color_held"}, int'(c_color), ec);
    endtask

    initial begin
        int  edges;
        bit  saw_done;
        reset  = 1'b1;
        start  = 1'b0;
        guess  = 15'd0;
        secret = 15'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_place", int'(c_place), 0);
        check("rst_color", int'(c_color), 0);
        @(negedge clk);
        reset = 1'b0;

        score(pk(1,2,3,4,5), pk(1,2,3,4,5), 5, 0, -1, 1'b0, "exact5");
        check_idle("exact5", 5, 0);

        score(pk(5,4,3,2,1), pk(1,2,3,4,5), 1, 4, -1, 1'b0, "rev");
        check_idle("rev", 1, 4);

        // Start held during DONE is ignored; next start accepted back-to-back.
        score(pk(1,2,1,0,0), pk(1,1,2,2,3), 1, 2, -1, 1'b1, "dups");
        score(pk(0,0,0,0,0), pk(7,7,7,7,7), 0, 0, -1, 1'b0, "none");
        check_idle("none", 0, 0);

        score(pk(5,4,3,2,1), pk(1,2,3,4,5), 1, 4, 10, 1'b0, "restart");
        check_idle("restart", 1, 4);

        // Reset at cycle 12 of busy aborts scoring.
        @(negedge clk);
        guess  = pk(1,2,3,4,5);
        secret = pk(1,2,3,4,5);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_place", int'(c_place), 0);
        check("abort_color", int'(c_color), 0);
        saw_done = 1'b0;
        edges    = 0;
        while (edges < 40) begin
            @(posedge clk);
            edges++;
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("abort_quiet", int'(saw_done), 0);

        score(pk(5,4,3,2,1), pk(1,2,3,4,5), 1, 4, -1, 1'b0, "post_rst");
        check_idle("post_rst", 1, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
